// File: rtl/v810_sysreg.sv
// v810_sysreg: V810 system-register file with the EP/NP exception entry sequencer.
// Serves STSR/LDSR, ALU flag writeback and RETI, and redirects fetch to handler or return PC.
module v810_sysreg #(
  parameter logic [31:0] PIR_VAL  = 32'h0000_5346,
  parameter logic [31:0] TKCW_VAL = 32'h0000_00E0
) (
  input  logic        clk,
  input  logic        res,
  input  logic [4:0]  sr_sel,
  output logic [31:0] sr_rdata,
  input  logic        sr_we,
  input  logic [31:0] sr_wdata,
  input  logic        fl_we,
  input  logic [3:0]  fl_in,
  input  logic        exc_valid,
  input  logic [15:0] exc_code,
  input  logic        exc_irq,
  input  logic [3:0]  exc_lvl,
  input  logic [31:0] exc_pc,
  output logic        exc_ack,
  input  logic        reti,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        irq_ok,
  output logic        fatal,
  output logic [31:0] psw
);

  typedef enum logic [4:0] {
    SR_EIPC  = 5'd0,
    SR_EIPSW = 5'd1,
    SR_FEPC  = 5'd2,
    SR_FEPSW = 5'd3,
    SR_ECR   = 5'd4,
    SR_PSW   = 5'd5,
    SR_PIR   = 5'd6,
    SR_TKCW  = 5'd7,
    SR_CHCW  = 5'd24,
    SR_ADTRE = 5'd25
  } sr_sel_t;

  typedef struct packed {
    logic c;
    logic ov;
    logic s;
    logic z;
  } aluflags_t;

  typedef struct packed {
    logic [11:0] rfu_hi;
    logic [3:0]  i;
    logic        np;
    logic        ep;
    logic        ae;
    logic        id;
    logic [1:0]  rfu_lo;
    logic [5:0]  fl;
    aluflags_t   flags;
  } psw_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ENTRY,
    ST_HALT
  } state_t;

  localparam logic [31:0] PSW_RESET = 32'h0000_8000;
  localparam logic [31:0] ECR_RESET = 32'h0000_FFF0;
  localparam logic [31:0] DUP_VEC   = 32'hFFFF_FFD0;

  state_t      state;
  psw_t        psw_q;
  logic [31:0] eipc_q;
  logic [31:0] eipsw_q;
  logic [31:0] fepc_q;
  logic [31:0] fepsw_q;
  logic [31:0] ecr_q;
  logic [31:0] chcw_q;
  logic [31:0] adtre_q;

  logic [3:0]  irq_next_lvl;
  logic        sr_apply;
  logic        flag_write;

  // Every PSW write path goes through here so RFU bits can never become set.
  function automatic psw_t clean_psw(input logic [31:0] value);
    psw_t p;
    p        = psw_t'(value);
    p.rfu_hi = '0;
    p.rfu_lo = '0;
    return p;
  endfunction

  assign psw          = psw_q;
  assign irq_ok       = !psw_q.id && !psw_q.ep && !psw_q.np && (exc_lvl >= psw_q.i);
  assign irq_next_lvl = (exc_lvl == 4'hF) ? 4'hF : exc_lvl + 4'd1;

  // LDSR and flag writeback lose to entry and RETI, but still land during ENTRY.
  assign sr_apply   = (state == ST_ENTRY) || ((state == ST_RUN) && !exc_valid && !reti);
  assign flag_write = fl_we && !(sr_we && (sr_sel == SR_PSW));

  always_comb begin
    sr_rdata = '0;
    case (sr_sel)
      SR_EIPC:  sr_rdata = eipc_q;
      SR_EIPSW: sr_rdata = eipsw_q;
      SR_FEPC:  sr_rdata = fepc_q;
      SR_FEPSW: sr_rdata = fepsw_q;
      SR_ECR:   sr_rdata = ecr_q;
      SR_PSW:   sr_rdata = psw_q;
      SR_PIR:   sr_rdata = PIR_VAL;
      SR_TKCW:  sr_rdata = TKCW_VAL;
      SR_CHCW:  sr_rdata = chcw_q;
      SR_ADTRE: sr_rdata = adtre_q;
      default:  sr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_RUN;
      psw_q   <= psw_t'(PSW_RESET);
      ecr_q   <= ECR_RESET;
      eipc_q  <= '0;
      eipsw_q <= '0;
      fepc_q  <= '0;
      fepsw_q <= '0;
      chcw_q  <= '0;
      adtre_q <= '0;
      exc_ack <= 1'b0;
      pc_load <= 1'b0;
      pc_out  <= '0;
      fatal   <= 1'b0;
    end else begin
      exc_ack <= 1'b0;
      pc_load <= 1'b0;

      unique case (state)
        ST_RUN: begin
          if (exc_valid) begin
            if (psw_q.np) begin
              state <= ST_HALT;
              fatal <= 1'b1;
            end else begin
              // A second exception while EP is set is the duplexed case.
              if (psw_q.ep) begin
                fepc_q        <= exc_pc;
                fepsw_q       <= psw_q;
                ecr_q[31:16]  <= exc_code;
                psw_q.np      <= 1'b1;
                pc_out        <= DUP_VEC;
              end else begin
                eipc_q        <= exc_pc;
                eipsw_q       <= psw_q;
                ecr_q[15:0]   <= exc_code;
                psw_q.ep      <= 1'b1;
                pc_out        <= {16'hFFFF, exc_code & 16'hFFF0};
              end
              psw_q.id <= 1'b1;
              psw_q.ae <= 1'b0;
              if (exc_irq) begin
                psw_q.i <= irq_next_lvl;
              end
              exc_ack <= 1'b1;
              pc_load <= 1'b1;
              state   <= ST_ENTRY;
            end
          end else if (reti) begin
            if (psw_q.np) begin
              psw_q  <= clean_psw(fepsw_q);
              pc_out <= fepc_q;
            end else begin
              psw_q  <= clean_psw(eipsw_q);
              pc_out <= eipc_q;
            end
            pc_load <= 1'b1;
          end
        end
        ST_ENTRY: state <= ST_RUN;
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_RUN;
      endcase

      if (sr_apply) begin
        if (sr_we) begin
          case (sr_sel)
            SR_EIPC:  eipc_q  <= sr_wdata;
            SR_EIPSW: eipsw_q <= sr_wdata;
            SR_FEPC:  fepc_q  <= sr_wdata;
            SR_FEPSW: fepsw_q <= sr_wdata;
            SR_PSW:   psw_q   <= clean_psw(sr_wdata);
            SR_CHCW:  chcw_q  <= sr_wdata;
            SR_ADTRE: adtre_q <= {sr_wdata[31:1], 1'b0};
            default:  ;
          endcase
        end
        if (flag_write) begin
          psw_q.flags <= aluflags_t'(fl_in);
        end
      end
    end
  end

endmodule

// File: tb/tb_v810_sysreg.sv
// tb_v810_sysreg: directed scenarios plus randomized traffic for v810_sysreg,
// checked against a register-level behavioural model of the system registers.
module tb_v810_sysreg;

  logic        clk = 1'b0;
  logic        res;
  logic [4:0]  sr_sel;
  logic [31:0] sr_rdata;
  logic        sr_we;
  logic [31:0] sr_wdata;
  logic        fl_we;
  logic [3:0]  fl_in;
  logic        exc_valid;
  logic [15:0] exc_code;
  logic        exc_irq;
  logic [3:0]  exc_lvl;
  logic [31:0] exc_pc;
  logic        exc_ack;
  logic        reti;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        irq_ok;
  logic        fatal;
  logic [31:0] psw;

  int n_checks = 0;
  int n_errors = 0;

  v810_sysreg dut (
    .clk(clk), .res(res),
    .sr_sel(sr_sel), .sr_rdata(sr_rdata), .sr_we(sr_we), .sr_wdata(sr_wdata),
    .fl_we(fl_we), .fl_in(fl_in),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_irq(exc_irq), .exc_lvl(exc_lvl),
    .exc_pc(exc_pc), .exc_ack(exc_ack), .reti(reti), .pc_load(pc_load), .pc_out(pc_out),
    .irq_ok(irq_ok), .fatal(fatal), .psw(psw)
  );

  always #10 clk = ~clk;

  // Architectural PSW bits: I[19:16], NP, EP, AE, ID, FL[9:4], flags[3:0].
  localparam logic [31:0] PSW_MASK = (32'hF << 16) | (32'h1 << 15) | (32'h1 << 14) |
                                     (32'h1 << 13) | (32'h1 << 12) | (32'h3F << 4) | 32'hF;

  logic [31:0] m_psw, m_eipc, m_eipsw, m_fepc, m_fepsw, m_ecr, m_chcw, m_adtre, m_pc_out;
  logic        m_ack, m_load, m_fatal;
  int          m_mode;  // 0 running, 1 entering handler, 2 halted

  logic [4:0] sel_list [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                5'd24, 5'd25, 5'd8, 5'd31};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_psw = 32'h0000_8000; m_ecr = 32'h0000_FFF0;
    m_eipc = 0; m_eipsw = 0; m_fepc = 0; m_fepsw = 0; m_chcw = 0; m_adtre = 0;
    m_pc_out = 0; m_ack = 0; m_load = 0; m_fatal = 0; m_mode = 0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] sel);
    case (sel)
      5'd0:    return m_eipc;
      5'd1:    return m_eipsw;
      5'd2:    return m_fepc;
      5'd3:    return m_fepsw;
      5'd4:    return m_ecr;
      5'd5:    return m_psw;
      5'd6:    return 32'h0000_5346;
      5'd7:    return 32'h0000_00E0;
      5'd24:   return m_chcw;
      5'd25:   return m_adtre;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelIrqOk(input logic [3:0] lvl);
    return !m_psw[12] && !m_psw[14] && !m_psw[15] && (int'(lvl) >= int'(m_psw[19:16]));
  endfunction

  task automatic modelStep();
    logic [31:0] pre;
    int nl;
    pre = m_psw;
    m_ack = 0; m_load = 0;
    if (m_mode == 2) return;
    if (m_mode == 0 && exc_valid) begin
      if (pre[15]) begin
        m_mode = 2; m_fatal = 1;
        return;
      end
      if (pre[14]) begin
        m_fepc = exc_pc; m_fepsw = pre; m_ecr = {exc_code, m_ecr[15:0]};
        m_psw[15] = 1'b1; m_pc_out = 32'hFFFF_FFD0;
      end else begin
        m_eipc = exc_pc; m_eipsw = pre; m_ecr = {m_ecr[31:16], exc_code};
        m_psw[14] = 1'b1; m_pc_out = 32'hFFFF_0000 + ((32'(exc_code) >> 4) << 4);
      end
      m_psw[12] = 1'b1; m_psw[13] = 1'b0;
      if (exc_irq) begin
        nl = int'(exc_lvl) + 1;
        if (nl > 15) nl = 15;
        m_psw[19:16] = 4'(nl);
      end
      m_ack = 1; m_load = 1; m_mode = 1;
      return;
    end
    if (m_mode == 0 && reti) begin
      if (pre[15]) begin m_psw = m_fepsw & PSW_MASK; m_pc_out = m_fepc; end
      else         begin m_psw = m_eipsw & PSW_MASK; m_pc_out = m_eipc; end
      m_load = 1;
      return;
    end
    m_mode = 0;
    if (sr_we) begin
      case (sr_sel)
        5'd0:  m_eipc  = sr_wdata;
        5'd1:  m_eipsw = sr_wdata;
        5'd2:  m_fepc  = sr_wdata;
        5'd3:  m_fepsw = sr_wdata;
        5'd5:  m_psw   = sr_wdata & PSW_MASK;
        5'd24: m_chcw  = sr_wdata;
        5'd25: m_adtre = sr_wdata - (sr_wdata % 2);
        default: ;
      endcase
    end
    if (fl_we && !(sr_we && sr_sel == 5'd5)) m_psw = (m_psw & ~32'hF) | 32'(fl_in);
  endtask

  task automatic setIdle();
    sr_we = 0; fl_we = 0; exc_valid = 0; reti = 0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_psw"}, psw, m_psw);
    checkOutput({tag, "_pcout"}, pc_out, m_pc_out);
    checkOutput({tag, "_ack"}, 32'(exc_ack), 32'(m_ack));
    checkOutput({tag, "_pcload"}, 32'(pc_load), 32'(m_load));
    checkOutput({tag, "_fatal"}, 32'(fatal), 32'(m_fatal));
  endtask

  // One clock with the currently driven inputs; combinational outputs are
  // checked before the edge and registered ones 1 ns after it.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput({tag, "_rdata"}, sr_rdata, modelRead(sr_sel));
    checkOutput({tag, "_irqok"}, 32'(irq_ok), 32'(modelIrqOk(exc_lvl)));
    @(posedge clk);
    modelStep();
    #1;
    checkRegs(tag);
  endtask

  task automatic doReset(input string tag);
    setIdle();
    res = 1;
    #2;
    modelReset();
    checkRegs(tag);
    res = 0;
    #1;
  endtask

  task automatic peek(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    setIdle();
    sr_sel = sel;
    #1;
    checkOutput(tag, sr_rdata, exp);
  endtask

  task automatic probeIrq(input string tag, input logic [3:0] lvl, input logic exp);
    exc_lvl = lvl;
    #1;
    checkOutput(tag, 32'(irq_ok), 32'(exp));
  endtask

  initial begin
    res = 0; sr_sel = 0; sr_wdata = 0; fl_in = 0; exc_code = 0; exc_irq = 0;
    exc_lvl = 0; exc_pc = 0;
    setIdle();
    modelReset();

    doReset("rst");
    checkOutput("rst_psw_const", psw, 32'h0000_8000);
    checkOutput("rst_pcout_const", pc_out, 32'h0);
    peek("rst_ecr", 5'd4, 32'h0000_FFF0);
    peek("rst_pir", 5'd6, 32'h0000_5346);
    peek("rst_tkcw", 5'd7, 32'h0000_00E0);
    sr_we = 1; sr_sel = 5'd6; sr_wdata = 0;
    applyStimulus("pir_wr");
    peek("pir_after_wr", 5'd6, 32'h0000_5346);

    // First exception from a clean PSW.
    sr_we = 1; sr_sel = 5'd5; sr_wdata = 0;
    applyStimulus("psw_clear");
    checkOutput("psw_clear_const", psw, 32'h0);
    exc_valid = 1; exc_code = 16'hFE40; exc_pc = 32'h1234; exc_irq = 0;
    applyStimulus("exc1");
    checkOutput("exc1_ack_const", 32'(exc_ack), 32'd1);
    checkOutput("exc1_pcout_const", pc_out, 32'hFFFF_FE40);
    checkOutput("exc1_psw_const", psw, 32'h0000_5000);
    peek("exc1_eipc", 5'd0, 32'h1234);
    peek("exc1_eipsw", 5'd1, 32'h0);
    peek("exc1_ecr", 5'd4, 32'h0000_FE40);
    applyStimulus("exc1_idle");
    checkOutput("exc1_ack_drop", 32'(exc_ack), 32'd0);

    // Duplexed exception then RETI through FEPC/FEPSW.
    exc_valid = 1; exc_code = 16'hFF60; exc_pc = 32'h5678;
    applyStimulus("exc2");
    checkOutput("exc2_pcout_const", pc_out, 32'hFFFF_FFD0);
    checkOutput("exc2_psw_const", psw, 32'h0000_D000);
    peek("exc2_ecr", 5'd4, 32'hFF60_FE40);
    peek("exc2_fepc", 5'd2, 32'h5678);
    peek("exc2_fepsw", 5'd3, 32'h0000_5000);
    applyStimulus("exc2_idle");
    reti = 1;
    applyStimulus("reti_np");
    checkOutput("reti_np_psw_const", psw, 32'h0000_5000);
    checkOutput("reti_np_pc_const", pc_out, 32'h5678);
    checkOutput("reti_np_load_const", 32'(pc_load), 32'd1);

    // Exception with NP set is fatal and freezes the core.
    doReset("fatal_rst");
    exc_valid = 1; exc_code = 16'h0010; exc_pc = 32'h40;
    applyStimulus("fatal");
    checkOutput("fatal_const", 32'(fatal), 32'd1);
    checkOutput("fatal_noack", 32'(exc_ack), 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus("fatal_hold");
    setIdle(); sr_we = 1; sr_sel = 5'd24; sr_wdata = 32'hDEAD_BEEF; reti = 1;
    applyStimulus("fatal_ldsr");
    peek("fatal_chcw", 5'd24, 32'h0);
    doReset("fatal_exit");
    checkOutput("fatal_cleared", 32'(fatal), 32'd0);

    // Interrupt level gating and level raise on entry.
    sr_we = 1; sr_sel = 5'd5; sr_wdata = 32'h0003_0000;
    applyStimulus("psw_i3");
    setIdle();
    probeIrq("irq_lvl2", 4'd2, 1'b0);
    probeIrq("irq_lvl3", 4'd3, 1'b1);
    probeIrq("irq_lvl15", 4'd15, 1'b1);
    exc_valid = 1; exc_irq = 1; exc_lvl = 4'd15; exc_code = 16'hFE10; exc_pc = 32'h88;
    applyStimulus("irq15");
    checkOutput("irq15_psw_const", psw, 32'h000F_5000);
    exc_irq = 0;

    // Same-edge collision: entry beats LDSR and FL_WE.
    doReset("prio_rst");
    sr_we = 1; sr_sel = 5'd5; sr_wdata = 32'h5;
    applyStimulus("prio_pre");
    fl_we = 1; fl_in = 4'b1010; sr_we = 1; sr_sel = 5'd5; sr_wdata = 0;
    exc_valid = 1; exc_code = 16'hFE40; exc_pc = 32'hABCD;
    applyStimulus("prio");
    checkOutput("prio_psw_const", psw, 32'h0000_5005);
    peek("prio_eipsw", 5'd1, 32'h5);

    // Reset during ENTRY drops the pending acknowledge.
    doReset("mid_rst_a");
    sr_we = 1; sr_sel = 5'd5; sr_wdata = 0;
    applyStimulus("mid_clr");
    exc_valid = 1; exc_code = 16'hFE20; exc_pc = 32'h99;
    applyStimulus("mid_exc");
    doReset("mid_rst_b");
    checkOutput("mid_ack_lost", 32'(exc_ack), 32'd0);
    applyStimulus("mid_idle");

    // FL_WE alongside a non-PSW LDSR, ADTRE bit0, PSW RFU masking.
    sr_we = 1; sr_sel = 5'd24; sr_wdata = 32'h1234_5678; fl_we = 1; fl_in = 4'b0110;
    applyStimulus("fl_chcw");
    checkOutput("fl_chcw_psw_const", psw, 32'h0000_8006);
    peek("fl_chcw_val", 5'd24, 32'h1234_5678);
    sr_we = 1; sr_sel = 5'd25; sr_wdata = 32'hFFFF_FFFF;
    applyStimulus("adtre");
    peek("adtre_val", 5'd25, 32'hFFFF_FFFE);
    sr_we = 1; sr_sel = 5'd5; sr_wdata = 32'hFFFF_FFFF;
    applyStimulus("psw_rfu");
    checkOutput("psw_rfu_const", psw, 32'h000F_F3FF);

    // Randomized traffic against the model.
    doReset("rnd_start");
    for (int n = 0; n < 3000; n++) begin
      if (($urandom_range(0, 59) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0))
        doReset("rnd_rst");
      setIdle();
      sr_sel    = sel_list[$urandom_range(0, 11)];
      sr_we     = ($urandom_range(0, 3) == 0);
      sr_wdata  = $urandom;
      fl_we     = ($urandom_range(0, 2) == 0);
      fl_in     = 4'($urandom);
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code  = 16'($urandom);
      exc_irq   = ($urandom_range(0, 1) == 1);
      exc_lvl   = 4'($urandom);
      exc_pc    = $urandom;
      reti      = ($urandom_range(0, 7) == 0);
      applyStimulus("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
